// File: rtl/axi_proxy_responder.sv
// ECD-side end of the AXI-over-stream proxy link.
// Executes one request packet as one AXI4-Lite transaction and returns a response.
module axi_proxy_responder #(
   parameter logic [7:0] PKT_TYPE = 8'd1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [511:0] AXIS_RX_TDATA,
   input  logic         AXIS_RX_TVALID,
   input  logic         AXIS_RX_TLAST,
   output logic         AXIS_RX_TREADY,
   output logic [255:0] AXIS_TX_TDATA,
   output logic         AXIS_TX_TVALID,
   output logic         AXIS_TX_TLAST,
   input  logic         AXIS_TX_TREADY,
   output logic [31:0]  M_AXI_AWADDR,
   output logic [2:0]   M_AXI_AWPROT,
   output logic         M_AXI_AWVALID,
   input  logic         M_AXI_AWREADY,
   output logic [31:0]  M_AXI_WDATA,
   output logic [3:0]   M_AXI_WSTRB,
   output logic         M_AXI_WVALID,
   input  logic         M_AXI_WREADY,
   input  logic [1:0]   M_AXI_BRESP,
   input  logic         M_AXI_BVALID,
   output logic         M_AXI_BREADY,
   output logic [31:0]  M_AXI_ARADDR,
   output logic [2:0]   M_AXI_ARPROT,
   output logic         M_AXI_ARVALID,
   input  logic         M_AXI_ARREADY,
   input  logic [31:0]  M_AXI_RDATA,
   input  logic [1:0]   M_AXI_RRESP,
   input  logic         M_AXI_RVALID,
   output logic         M_AXI_RREADY,
   output logic [31:0]  req_count,
   output logic [31:0]  drop_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_DRAIN, S_WRITE, S_READ,
      S_WAIT_B, S_WAIT_R, S_SEND
   } state_t;

   state_t        state_q, state_d;
   logic          rx_rdy_q, rx_rdy_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic          mode_q, mode_d;
   logic          pend_q, pend_d;
   logic          awv_q, awv_d;
   logic          wv_q, wv_d;
   logic          bre_q, bre_d;
   logic          arv_q, arv_d;
   logic          rre_q, rre_d;
   logic          txv_q, txv_d;
   logic [255:0]  txd_q, txd_d;
   logic [31:0]   req_q, req_d;
   logic [31:0]   drop_q, drop_d;
   logic          rx_hs;
   logic          go;

   // Payload bits above the mode flag are never interpreted.
   logic unused_bits;
   assign unused_bits = ^AXIS_RX_TDATA[503:65];

   assign rx_hs = rx_rdy_q & AXIS_RX_TVALID;

   always_comb begin
      state_d  = state_q;
      rx_rdy_d = rx_rdy_q;
      addr_d   = addr_q;
      data_d   = data_q;
      mode_d   = mode_q;
      pend_d   = pend_q;
      awv_d    = awv_q;
      wv_d     = wv_q;
      bre_d    = bre_q;
      arv_d    = arv_q;
      rre_d    = rre_q;
      txv_d    = txv_q;
      txd_d    = txd_q;
      req_d    = req_q;
      drop_d   = drop_q;
      go       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            rx_rdy_d = 1'b1;
            if (rx_hs) begin
               addr_d   = AXIS_RX_TDATA[31:0];
               data_d   = AXIS_RX_TDATA[63:32];
               mode_d   = AXIS_RX_TDATA[64];
               rx_rdy_d = 1'b0;
               if (AXIS_RX_TDATA[511:504] != PKT_TYPE) begin
                  drop_d = drop_q + 32'd1;
                  pend_d = 1'b0;
                  if (!AXIS_RX_TLAST) begin
                     state_d  = S_DRAIN;
                     rx_rdy_d = 1'b1;
                  end
               end else if (!AXIS_RX_TLAST) begin
                  state_d  = S_DRAIN;
                  pend_d   = 1'b1;
                  rx_rdy_d = 1'b1;
               end else begin
                  go = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (rx_hs && AXIS_RX_TLAST) begin
               rx_rdy_d = 1'b0;
               pend_d   = 1'b0;
               if (pend_q) go = 1'b1;
               else        state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            awv_d = awv_q & ~M_AXI_AWREADY;
            wv_d  = wv_q & ~M_AXI_WREADY;
            if (!awv_d && !wv_d) begin
               bre_d   = 1'b1;
               state_d = S_WAIT_B;
            end
         end
         S_READ: begin
            if (M_AXI_ARREADY) begin
               arv_d   = 1'b0;
               rre_d   = 1'b1;
               state_d = S_WAIT_R;
            end
         end
         S_WAIT_B: begin
            if (M_AXI_BVALID) begin
               bre_d   = 1'b0;
               txv_d   = 1'b1;
               txd_d   = {189'b0, 1'b0, M_AXI_BRESP, 32'b0, addr_q};
               state_d = S_SEND;
            end
         end
         S_WAIT_R: begin
            if (M_AXI_RVALID) begin
               rre_d   = 1'b0;
               txv_d   = 1'b1;
               txd_d   = {189'b0, 1'b0, M_AXI_RRESP, M_AXI_RDATA, addr_q};
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (AXIS_TX_TREADY) begin
               txv_d    = 1'b0;
               req_d    = req_q + 32'd1;
               rx_rdy_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // mode_d holds the freshly latched mode in IDLE and the stored one in DRAIN.
      if (go) begin
         if (mode_d) begin
            arv_d   = 1'b1;
            state_d = S_READ;
         end else begin
            awv_d   = 1'b1;
            wv_d    = 1'b1;
            state_d = S_WRITE;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         rx_rdy_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         mode_q   <= 1'b0;
         pend_q   <= 1'b0;
         awv_q    <= 1'b0;
         wv_q     <= 1'b0;
         bre_q    <= 1'b0;
         arv_q    <= 1'b0;
         rre_q    <= 1'b0;
         txv_q    <= 1'b0;
         txd_q    <= '0;
         req_q    <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         rx_rdy_q <= rx_rdy_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         mode_q   <= mode_d;
         pend_q   <= pend_d;
         awv_q    <= awv_d;
         wv_q     <= wv_d;
         bre_q    <= bre_d;
         arv_q    <= arv_d;
         rre_q    <= rre_d;
         txv_q    <= txv_d;
         txd_q    <= txd_d;
         req_q    <= req_d;
         drop_q   <= drop_d;
      end
   end

   assign AXIS_RX_TREADY = rx_rdy_q;
   assign AXIS_TX_TDATA  = txd_q;
   assign AXIS_TX_TVALID = txv_q;
   assign AXIS_TX_TLAST  = 1'b1;
   assign M_AXI_AWADDR   = addr_q;
   assign M_AXI_AWPROT   = 3'b000;
   assign M_AXI_AWVALID  = awv_q;
   assign M_AXI_WDATA    = data_q;
   assign M_AXI_WSTRB    = 4'hF;
   assign M_AXI_WVALID   = wv_q;
   assign M_AXI_BREADY   = bre_q;
   assign M_AXI_ARADDR   = addr_q;
   assign M_AXI_ARPROT   = 3'b000;
   assign M_AXI_ARVALID  = arv_q;
   assign M_AXI_RREADY   = rre_q;
   assign req_count      = req_q;
   assign drop_count     = drop_q;

endmodule

// File: tb/tb_axi_proxy_responder.sv
// Directed bench for axi_proxy_responder.
// Slave handshakes are driven step by step from the main sequence.
module tb_axi_proxy_responder;

   logic         clk;
   logic         resetn;
   logic [511:0] rx_tdata;
   logic         rx_tvalid;
   logic         rx_tlast;
   logic         rx_tready;
   logic [255:0] tx_tdata;
   logic         tx_tvalid;
   logic         tx_tlast;
   logic         tx_tready;
   logic [31:0]  awaddr;
   logic [2:0]   awprot;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [31:0]  araddr;
   logic [2:0]   arprot;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [31:0]  req_count;
   logic [31:0]  drop_count;

   int n_tests;
   int n_fail;

   axi_proxy_responder #(.PKT_TYPE(8'd1)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .AXIS_RX_TDATA  (rx_tdata),
      .AXIS_RX_TVALID (rx_tvalid),
      .AXIS_RX_TLAST  (rx_tlast),
      .AXIS_RX_TREADY (rx_tready),
      .AXIS_TX_TDATA  (tx_tdata),
      .AXIS_TX_TVALID (tx_tvalid),
      .AXIS_TX_TLAST  (tx_tlast),
      .AXIS_TX_TREADY (tx_tready),
      .M_AXI_AWADDR   (awaddr),
      .M_AXI_AWPROT   (awprot),
      .M_AXI_AWVALID  (awvalid),
      .M_AXI_AWREADY  (awready),
      .M_AXI_WDATA    (wdata),
      .M_AXI_WSTRB    (wstrb),
      .M_AXI_WVALID   (wvalid),
      .M_AXI_WREADY   (wready),
      .M_AXI_BRESP    (bresp),
      .M_AXI_BVALID   (bvalid),
      .M_AXI_BREADY   (bready),
      .M_AXI_ARADDR   (araddr),
      .M_AXI_ARPROT   (arprot),
      .M_AXI_ARVALID  (arvalid),
      .M_AXI_ARREADY  (arready),
      .M_AXI_RDATA    (rdata),
      .M_AXI_RRESP    (rresp),
      .M_AXI_RVALID   (rvalid),
      .M_AXI_RREADY   (rready),
      .req_count      (req_count),
      .drop_count     (drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [255:0] obs,
                      input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mk_resp(input logic [31:0] a,
                                            input logic [31:0] d,
                                            input logic [1:0]  r);
      logic [255:0] v;
      v = '0;
      v[31:0]  = a;
      v[63:32] = d;
      v[66:64] = {1'b0, r};
      return v;
   endfunction

   // One RX beat; returns one step after the handshake edge.
   task automatic rx_beat(input logic [7:0]  t,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          input logic        m,
                          input logic        last);
      logic [511:0] v;
      v = '0;
      v[511:504] = t;
      v[31:0]    = a;
      v[63:32]   = d;
      v[64]      = m;
      rx_tdata  = v;
      rx_tlast  = last;
      rx_tvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (rx_tready) break;
         tick();
      end
      chk("rx_ready_wait", {255'b0, rx_tready}, 256'd1);
      tick();
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
   endtask

   logic [255:0] exp_tx;

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      resetn    = 1'b0;
      rx_tdata  = '0;
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      tx_tready = 1'b1;
      awready   = 1'b1;
      wready    = 1'b1;
      bresp     = 2'd0;
      bvalid    = 1'b1;
      arready   = 1'b0;
      rdata     = '0;
      rresp     = 2'd0;
      rvalid    = 1'b0;

      repeat (3) tick();
      chk("rst_rx_ready", {255'b0, rx_tready}, 256'd0);
      chk("rst_valids", {250'b0, awvalid, wvalid, bready,
                         arvalid, rready, tx_tvalid}, 256'd0);
      chk("rst_req", {224'b0, req_count}, 256'd0);
      chk("rst_drop", {224'b0, drop_count}, 256'd0);
      chk("rst_txdata", tx_tdata, 256'd0);
      chk("const", {241'b0, awprot, arprot, wstrb, tx_tlast},
          {241'b0, 3'd0, 3'd0, 4'hF, 1'b1});
      resetn = 1'b1;
      tick();
      chk("idle_ready", {255'b0, rx_tready}, 256'd1);

      // Write, slaves always ready
      rx_beat(8'd1, 32'h0000_1000, 32'h0000_000F, 1'b0, 1'b1);
      chk("w1_awv_wv", {254'b0, awvalid, wvalid}, 256'd3);
      chk("w1_addr", {224'b0, awaddr}, 256'h1000);
      chk("w1_data", {224'b0, wdata}, 256'hF);
      chk("w1_rx_bp", {255'b0, rx_tready}, 256'd0);
      tick();
      chk("w1_bready", {253'b0, awvalid, wvalid, bready}, 256'd1);
      tick();
      chk("w1_txv", {254'b0, bready, tx_tvalid}, 256'd1);
      chk("w1_txd", tx_tdata, mk_resp(32'h1000, 32'h0, 2'd0));
      tick();
      chk("w1_txdone", {255'b0, tx_tvalid}, 256'd0);
      chk("w1_req", {224'b0, req_count}, 256'd1);
      tick();
      chk("w1_idle", {255'b0, rx_tready}, 256'd1);

      // Read with SLVERR
      arready = 1'b1;
      rvalid  = 1'b1;
      rdata   = 32'hCAFE_F00D;
      rresp   = 2'd2;
      rx_beat(8'd1, 32'h0000_0020, 32'h0, 1'b1, 1'b1);
      chk("r1_arv", {253'b0, arvalid, awvalid, wvalid}, 256'd4);
      chk("r1_addr", {224'b0, araddr}, 256'h20);
      tick();
      chk("r1_rready", {254'b0, arvalid, rready}, 256'd1);
      tick();
      chk("r1_txv", {253'b0, rready, tx_tvalid, awvalid}, 256'd2);
      chk("r1_txd", tx_tdata, mk_resp(32'h20, 32'hCAFE_F00D, 2'd2));
      tick();
      chk("r1_req", {224'b0, req_count}, 256'd2);
      arready = 1'b0;
      rvalid  = 1'b0;
      tick();

      // AWREADY late
      awready = 1'b0;
      wready  = 1'b1;
      rx_beat(8'd1, 32'h44, 32'h55, 1'b0, 1'b1);
      chk("sk1_c1", {254'b0, awvalid, wvalid}, 256'd3);
      tick();
      chk("sk1_c2", {253'b0, awvalid, wvalid, bready}, 256'd4);
      tick();
      chk("sk1_c3", {253'b0, awvalid, wvalid, bready}, 256'd4);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      chk("sk1_b", {253'b0, awvalid, wvalid, bready}, 256'd1);
      tick();
      chk("sk1_tx", {254'b0, bready, tx_tvalid}, 256'd1);
      chk("sk1_txd", tx_tdata, mk_resp(32'h44, 32'h0, 2'd0));
      tick();
      chk("sk1_req", {224'b0, req_count}, 256'd3);
      tick();

      // WREADY late, BRESP=3
      awready = 1'b1;
      wready  = 1'b0;
      bresp   = 2'd3;
      rx_beat(8'd1, 32'h48, 32'h66, 1'b0, 1'b1);
      tick();
      chk("sk2_c2", {253'b0, awvalid, wvalid, bready}, 256'd2);
      tick();
      chk("sk2_c3", {253'b0, awvalid, wvalid, bready}, 256'd2);
      wready = 1'b1;
      tick();
      chk("sk2_b", {253'b0, awvalid, wvalid, bready}, 256'd1);
      tick();
      chk("sk2_txd", tx_tdata, mk_resp(32'h48, 32'h0, 2'd3));
      tick();
      chk("sk2_req", {224'b0, req_count}, 256'd4);
      bresp = 2'd0;
      tick();

      // TX back-pressure
      tx_tready = 1'b0;
      rx_beat(8'd1, 32'h0ABC_0000, 32'h1, 1'b0, 1'b1);
      tick();
      tick();
      exp_tx = mk_resp(32'h0ABC_0000, 32'h0, 2'd0);
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold", {255'b0, tx_tvalid}, 256'd1);
         chk("bp_data", tx_tdata, exp_tx);
         chk("bp_rx", {255'b0, rx_tready}, 256'd0);
         tick();
      end
      tx_tready = 1'b1;
      tick();
      chk("bp_rel", {255'b0, tx_tvalid}, 256'd0);
      chk("bp_req", {224'b0, req_count}, 256'd5);
      tick();

      // Wrong type, single beat
      rx_beat(8'd2, 32'h77, 32'h88, 1'b0, 1'b1);
      chk("drop_cnt", {224'b0, drop_count}, 256'd1);
      tick();
      chk("drop_quiet", {252'b0, awvalid, wvalid, arvalid, tx_tvalid},
          256'd0);
      chk("drop_ready", {255'b0, rx_tready}, 256'd1);
      chk("drop_req", {224'b0, req_count}, 256'd5);

      // Three-beat write: only beat 0 executes
      rx_beat(8'd1, 32'h80, 32'h99, 1'b0, 1'b0);
      chk("mb_drain", {254'b0, awvalid, rx_tready}, 256'd1);
      rx_beat(8'd7, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
      chk("mb_b1", {253'b0, awvalid, arvalid, rx_tready}, 256'd1);
      rx_beat(8'd1, 32'h1111, 32'h2222, 1'b1, 1'b1);
      chk("mb_exec", {254'b0, awvalid, arvalid}, 256'd2);
      chk("mb_addr", {192'b0, awaddr, wdata}, {192'b0, 32'h80, 32'h99});
      tick();
      tick();
      chk("mb_txd", tx_tdata, mk_resp(32'h80, 32'h0, 2'd0));
      tick();
      chk("mb_cnts", {192'b0, req_count, drop_count},
          {192'b0, 32'd6, 32'd1});
      tick();

      // Reset while in WAIT_R
      arready = 1'b1;
      rvalid  = 1'b0;
      rx_beat(8'd1, 32'h30, 32'h0, 1'b1, 1'b1);
      tick();
      chk("mr_wait_r", {255'b0, rready}, 256'd1);
      #2 resetn = 1'b0;
      #1;
      chk("mr_async", {249'b0, rx_tready, awvalid, wvalid, bready,
                       arvalid, rready, tx_tvalid}, 256'd0);
      chk("mr_cnts", {192'b0, req_count, drop_count}, 256'd0);
      tick();
      #2 resetn = 1'b1;
      tick();
      chk("mr_idle", {255'b0, rx_tready}, 256'd1);
      rvalid = 1'b1;
      rdata  = 32'h0000_1234;
      rresp  = 2'd0;
      rx_beat(8'd1, 32'h40, 32'h0, 1'b1, 1'b1);
      tick();
      tick();
      chk("mr_txd", tx_tdata, mk_resp(32'h40, 32'h1234, 2'd0));
      tick();
      chk("mr_req", {224'b0, req_count}, 256'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_proxy_responder.md
Name: axi_proxy_responder

Overview:
- Far end of the AXI-over-stream proxy link, on the ECD side.
- Accepts request packets from the stream link: packet type in [511:504], address [31:0], data [63:32], mode bit [64] (0 = write, 1 = read).
- Executes each request as one AXI4-Lite master transaction.
- Returns one response packet per request on a 256-bit stream: address echo, read data and response code.

Parameters:
PKT_TYPE, 1, value of TDATA[511:504] that identifies a proxy request; any other value is dropped.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
AXIS_RX_TDATA / TVALID / TLAST / TREADY  in/in/in/out  512/1/1/1  request stream
AXIS_TX_TDATA / TVALID / TLAST / TREADY  out/out/out/in  256/1/1/1  response stream
M_AXI_AWADDR / AWPROT / AWVALID / AWREADY  out/out/out/in  32/3/1/1  write address channel
M_AXI_WDATA / WSTRB / WVALID / WREADY  out/out/out/in  32/4/1/1  write data channel
M_AXI_BRESP / BVALID / BREADY  in/in/out  2/1/1  write response channel
M_AXI_ARADDR / ARPROT / ARVALID / ARREADY  out/out/out/in  32/3/1/1  read address channel
M_AXI_RDATA / RRESP / RVALID / RREADY  in/in/in/out  32/2/1/1  read data channel
req_count  out  32  requests completed (response handshaken)
drop_count  out  32  packets discarded for a wrong type

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn; every register clears immediately when resetn=0.
- Reset values:
  - All VALID/READY outputs are 0, including AXIS_RX_TREADY.
  - Counters are 0.
  - AXIS_TX_TDATA is 0.
  - State is IDLE.
- Constant outputs: AWPROT=ARPROT=0, WSTRB=4'hF, AXIS_TX_TLAST=1.
- Registered outputs: all outputs except the constants above are registered.
- IDLE:
  - AXIS_RX_TREADY=1 (registered; rises the first cycle after reset release).
  - On an RX handshake: latch address, data and mode; drop TREADY.
  - If TDATA[511:504]!=PKT_TYPE: drop_count+1 and go to DRAIN (or stay in IDLE if TLAST=1).
  - Else if TLAST=0: go to DRAIN with a pending-execute flag set.
  - Else: dispatch.
- DRAIN:
  - TREADY=1; discard beats until a TLAST handshake.
  - Then dispatch if the pending flag is set, otherwise return to IDLE.
  - Only beat 0 of a packet is ever interpreted.
- Dispatch, write (mode=0):
  - Assert AWVALID and WVALID together with the latched address and data; state WRITE.
  - Each VALID drops independently on its own handshake; when both are done, go to WAIT_B with BREADY=1.
- Dispatch, read (mode=1):
  - ARVALID=1; state READ.
  - On the AR handshake: ARVALID=0, RREADY=1, go to WAIT_R.
- WAIT_B: on the B handshake, BREADY=0, resp=BRESP, data field=0; go to SEND.
- WAIT_R: on the R handshake, RREADY=0, resp=RRESP, data=RDATA; go to SEND.
- SEND:
  - Drive AXIS_TX_TDATA: [31:0] latched address, [63:32] data, [66:64] = {1'b0, resp}, all other bits 0.
  - Hold TVALID=1 and TDATA stable until TREADY.
  - On the handshake: TVALID=0, req_count+1, go to IDLE (TREADY=1 the next cycle).
- Flow control:
  - Exactly one request is outstanding at a time.
  - RX is back-pressured (TREADY=0) from acceptance until the response handshake.
  - Minimum turnaround with all slaves always ready: accept at cycle N, AW/W valid at N+1, B accepted N+2, TX valid N+3, IDLE N+4.
- Counters wrap at 2^32 with no saturation.
- Same-cycle events: AW and W handshakes may occur in the same cycle or in either order. VALID never drops before its handshake.
- No timeout: a hung slave stalls the block until reset.
- Reset mid-transaction: all VALIDs drop immediately and the in-flight request is abandoned with no response.

Test Plan:
- Write, slaves always ready: RX addr=0x0000_1000, data=0x0000_000F, mode=0, type=1 → AW/W carry 0x1000/0xF with WSTRB=F; BRESP=0 → TX [31:0]=0x1000, [63:32]=0, [66:64]=0; req_count=1.
- Read with SLVERR: RX addr=0x20, mode=1; slave returns RDATA=0xCAFE_F00D, RRESP=2 → TX [63:32]=0xCAFEF00D, [66:64]=2; no AW/W activity.
- Skewed write handshakes: AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID holds 3 cycles, exactly one B accepted; repeat with WREADY late.
- TX back-pressure: TX TREADY=0 for 10 cycles → TDATA stable, TVALID held, RX TREADY=0 throughout; response released on the first TREADY=1.
- Wrong type and multi-beat: type=2 single beat → drop_count=1, no AXI traffic, no TX. Then a 3-beat type-1 write → only beat 0 executed, beats 1-2 consumed, one TX response.
- Reset mid-operation: assert resetn=0 while in WAIT_R → all VALID/READY outputs 0 asynchronously. After release: IDLE, counters 0, next request handled normally.
